// File: rtl/ddc_iq_pair_pack_pkg.sv
// Shared channel-index codes and pairing FSM states for the DDC I/Q pair packer.
package ddc_pkg;

  localparam logic [3:0] CH_IDX_NONE = 4'd0;
  localparam logic [3:0] CH_IDX_I    = 4'd1;
  localparam logic [3:0] CH_IDX_Q    = 4'd2;

  typedef enum logic {
    WAIT_I,
    WAIT_Q
  } pair_state_e;

endpackage

// File: rtl/ddc_iq_pair_pack_if.sv
// Sample-in / packed-word-out bundle of the DDC I/Q pair packer.
// The master side drives samples and consumes words; the packer is the slave.
interface ddc_iq_pair_pack_if #(
  parameter int INPUT_WIDTH = 24
);

  logic [INPUT_WIDTH-1:0]   data_in;
  logic                     data_in_valid;
  logic [3:0]               data_in_ch_idx;
  logic [2*INPUT_WIDTH-1:0] pack_data;
  logic                     pack_valid;
  logic                     pack_ready;

  modport master (
    output data_in,
    output data_in_valid,
    output data_in_ch_idx,
    output pack_ready,
    input  pack_data,
    input  pack_valid
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    input  data_in_ch_idx,
    input  pack_ready,
    output pack_data,
    output pack_valid
  );

endinterface

// File: rtl/ddc_iq_pair_pack_fifo.sv
// Synchronous first-word-fall-through FIFO for packed {Q,I} words.
// Read data is forced to zero while empty so the output bus is clean after reset.
module ddc_iq_pack_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign rd_ok = rd_en && !empty;
  // A pop on the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ddc_iq_pair_pack.sv
// Pairs I/Q sample strobes into {Q,I} words, buffers them and flags sequence, timeout and overflow faults.
// Optional feature macro: DDC_IQ_PACK_STATS_EN adds pair_cnt / drop_cnt statistics outputs.
module ddc_iq_pair_pack
  import ddc_pkg::*;
#(
  parameter int INPUT_WIDTH  = 24,
  parameter int FIFO_DEPTH   = 16,
  parameter int PAIR_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ddc_iq_pair_pack_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_seq,
  output logic                        err_timeout,
  output logic                        overflow,
  input  logic                        overflow_clr
`ifdef DDC_IQ_PACK_STATS_EN
  ,
  output logic [31:0]                 pair_cnt,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int PW = 2 * INPUT_WIDTH;
  localparam int TW = (PAIR_TIMEOUT > 1) ? $clog2(PAIR_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (PAIR_TIMEOUT > 0) ? TW'(PAIR_TIMEOUT - 1) : '0;

  pair_state_e            state_q, state_d;
  logic [INPUT_WIDTH-1:0] held_i_q, held_i_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   push_q, push_d;
  logic [PW-1:0]          push_word_q, push_word_d;
  logic                   seq_err_d;
  logic                   timeout_d;
  logic                   is_i;
  logic                   is_q;
  logic                   timer_expired;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   ovf_drop;

  assign is_i = bus.data_in_valid && (bus.data_in_ch_idx == CH_IDX_I);
  assign is_q = bus.data_in_valid && (bus.data_in_ch_idx == CH_IDX_Q);
  assign timer_expired = (PAIR_TIMEOUT != 0) && (timer_q == TIMER_LAST);

  // Q takes priority over an expiring timer, so a pair arriving on the last cycle is still packed.
  always_comb begin
    state_d     = state_q;
    held_i_d    = held_i_q;
    timer_d     = timer_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    seq_err_d   = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      WAIT_I: begin
        if (is_i) begin
          held_i_d = bus.data_in;
          timer_d  = '0;
          state_d  = WAIT_Q;
        end else if (is_q) begin
          seq_err_d = 1'b1;
        end
      end
      WAIT_Q: begin
        if (is_q) begin
          push_d      = 1'b1;
          push_word_d = {bus.data_in, held_i_q};
          state_d     = WAIT_I;
        end else if (is_i) begin
          held_i_d  = bus.data_in;
          timer_d   = '0;
          seq_err_d = 1'b1;
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = WAIT_I;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = WAIT_I;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_I;
      held_i_q    <= '0;
      timer_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_i_q    <= held_i_d;
      timer_q     <= timer_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      err_seq     <= seq_err_d;
      err_timeout <= timeout_d;
    end
  end

  assign bus.pack_valid = !fifo_empty;
  assign pop      = bus.pack_valid && bus.pack_ready;
  assign ovf_drop = push_q && fifo_full && !pop;

  ddc_iq_pack_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_q),
    .wr_data (push_word_q),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (bus.pack_data),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef DDC_IQ_PACK_STATS_EN
  logic [1:0] drop_inc;

  // An FSM drop and an overflow drop from the previous pair can land on the same cycle.
  assign drop_inc = {1'b0, seq_err_d | timeout_d} + {1'b0, ovf_drop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      drop_cnt <= '0;
    end else if (overflow_clr) begin
      pair_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_q && !ovf_drop) begin
        pair_cnt <= pair_cnt + 1'b1;
      end
      drop_cnt <= drop_cnt + 16'(drop_inc);
    end
  end
`endif

endmodule

// File: tb/tb_ddc_iq_pair_pack.sv
// Scoreboard bench for ddc_iq_pair_pack: a pairing model queues expected words, a negedge monitor checks them.
module tb_ddc_iq_pair_pack;
  import ddc_pkg::*;

  localparam int W     = 24;
  localparam int DEPTH = 16;
  localparam int TMO   = 64;

  logic       clk;
  logic       rst_n;
  logic [4:0] fifo_level;
  logic       err_seq;
  logic       err_timeout;
  logic       overflow;
  logic       overflow_clr;
`ifdef DDC_IQ_PACK_STATS_EN
  logic [31:0] pair_cnt;
  logic [15:0] drop_cnt;
`endif

  ddc_iq_pair_pack_if #(.INPUT_WIDTH(W)) bus ();

  ddc_iq_pair_pack #(
    .INPUT_WIDTH  (W),
    .FIFO_DEPTH   (DEPTH),
    .PAIR_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .err_seq      (err_seq),
    .err_timeout  (err_timeout),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef DDC_IQ_PACK_STATS_EN
    ,
    .pair_cnt     (pair_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            seq_seen = 0;
  int            tmo_seen = 0;
  int            exp_seq = 0;
  int            exp_tmo = 0;
  int            extra_words = 0;
  logic [2*W-1:0] sb [$];
  logic [W-1:0]   m_held = '0;
  logic           m_wait = 1'b0;
  logic           drop_next = 1'b0;
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_data = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe cycle; the model mirrors the pairing rules and queues the expected word.
  task automatic applyStimulus(input logic [3:0] ch, input logic [W-1:0] d);
    bus.data_in        = d;
    bus.data_in_ch_idx = ch;
    bus.data_in_valid  = 1'b1;
    if (ch == CH_IDX_I) begin
      if (m_wait) exp_seq++;
      m_held = d;
      m_wait = 1'b1;
    end else if (ch == CH_IDX_Q) begin
      if (!m_wait) begin
        exp_seq++;
      end else begin
        if (drop_next) drop_next = 1'b0;
        else sb.push_back({d, m_held});
        m_wait = 1'b0;
      end
    end
    tick();
    bus.data_in_valid  = 1'b0;
    bus.data_in_ch_idx = CH_IDX_NONE;
  endtask

  task automatic sendPair(input logic [W-1:0] i_val, input logic [W-1:0] q_val);
    applyStimulus(CH_IDX_I, i_val);
    applyStimulus(CH_IDX_Q, q_val);
  endtask

  task automatic waitDrain(input string tag, input int max_cycles);
    for (int k = 0; k < max_cycles && sb.size() > 0; k++) tick();
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (err_seq) seq_seen++;
      if (err_timeout) tmo_seen++;
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(bus.pack_valid), 64'd1);
        checkOutput("hold_data", 64'(bus.pack_data), 64'(prev_data));
      end
      if (bus.pack_valid && bus.pack_ready) begin
        if (sb.size() == 0) extra_words++;
        else checkOutput("word", 64'(bus.pack_data), 64'(sb.pop_front()));
      end
      prev_stall = bus.pack_valid && !bus.pack_ready;
      prev_data  = bus.pack_data;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    overflow_clr       = 1'b0;
    bus.data_in        = '0;
    bus.data_in_valid  = 1'b0;
    bus.data_in_ch_idx = CH_IDX_NONE;
    bus.pack_ready     = 1'b1;
    repeat (3) tick();
    checkOutput("rst_valid", 64'(bus.pack_valid), 64'd0);
    checkOutput("rst_data", 64'(bus.pack_data), 64'd0);
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_seq", 64'(err_seq), 64'd0);
    checkOutput("rst_tmo", 64'(err_timeout), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single pair with a gap, then latency of the registered push and FWFT read.
    applyStimulus(CH_IDX_I, 24'h000123);
    tick();
    tick();
    applyStimulus(CH_IDX_Q, 24'hFFFF00);
    checkOutput("t1_valid_early", 64'(bus.pack_valid), 64'd0);
    tick();
    checkOutput("t1_valid", 64'(bus.pack_valid), 64'd1);
    checkOutput("t1_data", 64'(bus.pack_data), 64'h0000_FFFF00_000123);
    checkOutput("t1_level1", 64'(fifo_level), 64'd1);
    tick();
    checkOutput("t1_level0", 64'(fifo_level), 64'd0);

    // Orphan Q, replaced I, ignored channel codes.
    applyStimulus(CH_IDX_Q, 24'h000055);
    applyStimulus(4'd3, 24'h00AAAA);
    applyStimulus(CH_IDX_I, 24'd5);
    applyStimulus(CH_IDX_I, 24'd7);
    applyStimulus(4'd0, 24'h00BBBB);
    applyStimulus(CH_IDX_Q, 24'd9);
    repeat (3) tick();
    checkOutput("t2_seq", 64'(seq_seen), 64'(exp_seq));
    waitDrain("t2_drain", 10);

    // Pair completes inside the timeout window; then an I is abandoned past it.
    applyStimulus(CH_IDX_I, 24'h111111);
    repeat (TMO - 4) tick();
    applyStimulus(CH_IDX_Q, 24'h222222);
    waitDrain("t3_pair", 10);
    checkOutput("t3_no_tmo", 64'(tmo_seen), 64'(exp_tmo));
    applyStimulus(CH_IDX_I, 24'h333333);
    repeat (TMO + 6) tick();
    m_wait = 1'b0;
    exp_tmo++;
    checkOutput("t3_tmo", 64'(tmo_seen), 64'(exp_tmo));
    checkOutput("t3_seq_before", 64'(seq_seen), 64'(exp_seq));
    applyStimulus(CH_IDX_Q, 24'h444444);
    repeat (2) tick();
    checkOutput("t3_seq_after", 64'(seq_seen), 64'(exp_seq));

    // Fill with Ready low; the seventeenth pair must be dropped and flagged.
    bus.pack_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) sendPair(24'($urandom), 24'($urandom));
    tick();
    checkOutput("t4_level_full", 64'(fifo_level), 64'(DEPTH));
    checkOutput("t4_ovf_before", 64'(overflow), 64'd0);
    drop_next = 1'b1;
    sendPair(24'h0BAD01, 24'h0BAD02);
    tick();
    checkOutput("t4_ovf", 64'(overflow), 64'd1);
    checkOutput("t4_level_kept", 64'(fifo_level), 64'(DEPTH));
    bus.pack_ready = 1'b1;
    waitDrain("t4_drain", 40);
    tick();
    checkOutput("t4_level_empty", 64'(fifo_level), 64'd0);
    checkOutput("t4_ovf_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("t4_ovf_clr", 64'(overflow), 64'd0);

    // Full FIFO: a pop on the same cycle as the registered write lets the word in.
    bus.pack_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) sendPair(24'($urandom), 24'($urandom));
    applyStimulus(CH_IDX_I, 24'h0C0FFE);
    applyStimulus(CH_IDX_Q, 24'h0FACE0);
    bus.pack_ready = 1'b1;
    tick();
    bus.pack_ready = 1'b0;
    checkOutput("t5_level", 64'(fifo_level), 64'(DEPTH));
    tick();
    checkOutput("t5_no_ovf", 64'(overflow), 64'd0);
    bus.pack_ready = 1'b1;
    waitDrain("t5_drain", 40);

    // Reset in WAIT_Q with five words queued.
    bus.pack_ready = 1'b0;
    for (int k = 0; k < 5; k++) sendPair(24'($urandom), 24'($urandom));
    applyStimulus(CH_IDX_I, 24'h0ABCDE);
    tick();
    checkOutput("t6_level5", 64'(fifo_level), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", 64'(bus.pack_valid), 64'd0);
    checkOutput("t6_data", 64'(bus.pack_data), 64'd0);
    checkOutput("t6_level", 64'(fifo_level), 64'd0);
    checkOutput("t6_ovf", 64'(overflow), 64'd0);
    sb.delete();
    m_wait = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.pack_ready = 1'b1;
    tick();
    applyStimulus(CH_IDX_Q, 24'h0DEAD0);
    repeat (3) tick();
    checkOutput("t6_seq", 64'(seq_seen), 64'(exp_seq));
    checkOutput("t6_level_after", 64'(fifo_level), 64'd0);

    checkOutput("extra_words", 64'(extra_words), 64'd0);
    checkOutput("sb_left", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
